// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with branch/jump/call/return next-PC selection and a circular return-address stack.
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INC = 4,
  parameter int OFFSET_W = 16,
  parameter int JIDX_W = 26,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [2:0]          sel,
  input  logic                branch_taken,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [JIDX_W-1:0]   jidx,
  input  logic [WIDTH-1:0]    reg_target,
  output logic [WIDTH-1:0]    pc_out,
  output logic [WIDTH-1:0]    pc_plus_inc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] count;
  logic [WIDTH-1:0] p, br_off, jmp, top, nxt;
  logic push, pop, uf;
  assign p = pc_out + WIDTH'(INC);
  assign pc_plus_inc = p;
  assign br_off = {{(WIDTH-OFFSET_W){offset[OFFSET_W-1]}}, offset} << 2;
  assign jmp = {p[WIDTH-1:JIDX_W+2], jidx, 2'b00};
  // ptr addresses the next free slot, so the top of stack sits one below it
  assign top = ras[ptr - PW'(1)];
  assign ras_empty = count == '0;
  assign ras_full = count == (PW+1)'(RAS_DEPTH);
  always_comb begin
    push = !stall && sel == 3'd4;
    pop = !stall && sel == 3'd5 && !ras_empty;
    uf = sel == 3'd5 && ras_empty;
    nxt = sel == 3'd1 ? (branch_taken ? p + br_off : p) :
          (sel == 3'd2 || sel == 3'd4) ? jmp :
          sel == 3'd3 ? reg_target :
          sel == 3'd5 ? (uf ? reg_target : top) : p;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_VECTOR;
      ptr <= '0;
      count <= '0;
      ras_underflow <= 1'b0;
    end else if (stall) begin
      ras_underflow <= 1'b0;
    end else begin
      pc_out <= nxt;
      ras_underflow <= uf;
      if (push) begin
        ptr <= ptr + PW'(1);
        count <= ras_full ? count : count + (PW+1)'(1);
      end
      if (pop) begin
        ptr <= ptr - PW'(1);
        count <= count - (PW+1)'(1);
      end
    end
  end
  // stack storage carries no reset; the count alone decides validity
  always_ff @(posedge clk) begin
    if (!reset && push) ras[ptr] <= p;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan steps plus random traffic checked against a queue-based reference model.
module tb_pc_sequencer;
  logic clk = 0, reset = 0, stall = 0, branch_taken = 0;
  logic [2:0] sel = 0;
  logic [15:0] offset = 0;
  logic [25:0] jidx = 0;
  logic [31:0] reg_target = 0;
  logic [31:0] pc_out, pc_plus_inc;
  logic ras_empty, ras_full, ras_underflow;
  int tests = 0, failed = 0;
  logic [31:0] mpc;
  logic muf;
  logic [31:0] q[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .sel(sel), .branch_taken(branch_taken),
    .offset(offset), .jidx(jidx), .reg_target(reg_target), .pc_out(pc_out),
    .pc_plus_inc(pc_plus_inc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] se, input logic bt,
                      input logic [15:0] off, input logic [25:0] ji, input logic [31:0] rt);
    logic [31:0] p, jt;
    reset = r; stall = s; sel = se; branch_taken = bt; offset = off; jidx = ji; reg_target = rt;
    @(posedge clk);
    p = mpc + 4;
    jt = (p & 32'hF000_0000) | ({6'b0, ji} * 4);
    muf = 0;
    if (r) begin
      mpc = 0;
      q.delete();
    end else if (!s) begin
      case (se)
        3'd1: mpc = bt ? p + 32'($signed(off)) * 4 : p;
        3'd2: mpc = jt;
        3'd3: mpc = rt;
        3'd4: begin
          q.push_back(p);
          if (q.size() > 4) void'(q.pop_front());
          mpc = jt;
        end
        3'd5: if (q.size() > 0) mpc = q.pop_back(); else begin mpc = rt; muf = 1; end
        default: mpc = p;
      endcase
    end
    #1;
    chk("pc_out", pc_out, mpc);
    chk("pc_plus_inc", pc_plus_inc, mpc + 4);
    chk("ras_empty", 32'(ras_empty), 32'(q.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(q.size() == 4));
    chk("ras_underflow", 32'(ras_underflow), 32'(muf));
  endtask

  initial begin
    mpc = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", pc_out, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc", pc_out, 32'h10);
    chk("seq_empty", 32'(ras_empty), 1);
    step(0, 0, 3, 0, 0, 0, 32'h8);
    step(0, 0, 1, 1, 16'hFFFE, 0, 0);
    chk("br_taken", pc_out, 32'h4);
    step(0, 0, 3, 0, 0, 0, 32'h8);
    step(0, 0, 1, 0, 16'hFFFE, 0, 0);
    chk("br_not_taken", pc_out, 32'hC);
    step(0, 0, 3, 0, 0, 0, 32'h4000_0010);
    step(0, 0, 2, 0, 0, 26'h100, 0);
    chk("jump", pc_out, 32'h4000_0400);
    step(0, 0, 3, 0, 0, 0, 32'h1234_5678);
    chk("jump_reg", pc_out, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3, 0, 0, 0, 32'(i) * 32'h100);
      step(0, 0, 4, 0, 0, 26'h400, 0);
    end
    chk("ras_full_after_5", 32'(ras_full), 1);
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 5, 0, 0, 0, 32'hDEAD_0000);
      chk("ret_pc", pc_out, 32'(i) * 32'h100 + 32'h4);
    end
    chk("ret_empty", 32'(ras_empty), 1);
    step(0, 0, 5, 0, 0, 0, 32'hABC0);
    chk("uf_pc", pc_out, 32'hABC0);
    chk("uf_pulse", 32'(ras_underflow), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("uf_clear", 32'(ras_underflow), 0);
    step(0, 0, 3, 0, 0, 0, 32'h20);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4, 0, 0, 26'h40, 0);
      chk("stall_pc", pc_out, 32'h20);
      chk("stall_empty", 32'(ras_empty), 1);
    end
    step(0, 0, 4, 0, 0, 26'h40, 0);
    chk("call_pc", pc_out, 32'h100);
    step(0, 0, 5, 0, 0, 0, 0);
    chk("call_pushed", pc_out, 32'h24);
    step(0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap", pc_out, 32'h0);
    step(0, 0, 4, 0, 0, 26'h10, 0);
    step(0, 0, 4, 0, 0, 26'h20, 0);
    step(1, 0, 5, 0, 0, 0, 32'h5555);
    chk("reset_mid_pc", pc_out, 32'h0);
    chk("reset_mid_empty", 32'(ras_empty), 1);
    step(0, 0, 5, 0, 0, 0, 32'h80);
    chk("reset_uf_pc", pc_out, 32'h80);
    chk("reset_uf_pulse", 32'(ras_underflow), 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) == 0, $urandom_range(7) == 0, 3'($urandom_range(7)),
           1'($urandom), 16'($urandom), 26'($urandom), $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
